// File: rtl/brq_wb_pkg.sv
// brq_wb_pkg: shared types and defaults for the writeback writer slice
package brq_wb_pkg;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_FIFO,
        SRC_BYPASS
    } wb_src_e;
endpackage

// File: rtl/brq_wb_writer_if.sv
// brq_wb_writer_if: issue/hazard, ALU, LSU and register-file write port bundle
interface brq_wb_writer_if
    import brq_wb_pkg::*;
#(
    parameter int DataWidth    = DATA_W,
    parameter int AddrRegWidth = REG_AW,
    parameter int FifoDepth    = 4
);
    logic                           issue_valid;
    logic                           issue_long;
    logic [AddrRegWidth-1:0]        issue_rd;
    logic [AddrRegWidth-1:0]        chk_rs1;
    logic [AddrRegWidth-1:0]        chk_rs2;
    logic [AddrRegWidth-1:0]        chk_rd;
    logic                           hazard_stall;
    logic                           alu_valid;
    logic [AddrRegWidth-1:0]        alu_rd;
    logic [DataWidth-1:0]           alu_data;
    logic                           lsu_valid;
    logic [AddrRegWidth-1:0]        lsu_rd;
    logic [DataWidth-1:0]           lsu_data;
    logic                           lsu_ready;
    logic                           writeEn;
    logic [AddrRegWidth-1:0]        writeDataSel;
    logic [DataWidth-1:0]           writeData;
    logic [$clog2(FifoDepth):0]     fifo_count;

    modport master (
        output issue_valid, issue_long, issue_rd, chk_rs1, chk_rs2, chk_rd,
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        input  hazard_stall, lsu_ready, writeEn, writeDataSel, writeData, fifo_count
    );

    modport slave (
        input  issue_valid, issue_long, issue_rd, chk_rs1, chk_rs2, chk_rd,
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        output hazard_stall, lsu_ready, writeEn, writeDataSel, writeData, fifo_count
    );
endinterface

// File: rtl/brq_wb_fifo.sv
// brq_wb_fifo: circular buffer holding LSU results that lost arbitration
module brq_wb_fifo
    import brq_wb_pkg::*;
#(
    parameter int Width = REG_AW + DATA_W,
    parameter int Depth = 4
) (
    input  logic                     brq_clk,
    input  logic                     brq_rst_n,
    input  logic                     push,
    input  logic [Width-1:0]         push_data,
    input  logic                     pop,
    output logic [Width-1:0]         pop_data,
    output logic [$clog2(Depth):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AddrWidth = $clog2(Depth);
    localparam int CntWidth  = AddrWidth + 1;

    logic [Width-1:0]     mem [Depth];
    logic [AddrWidth-1:0] wr_ptr, rd_ptr;

    assign pop_data = mem[rd_ptr];
    assign full     = count == CntWidth'(Depth);
    assign empty    = count == '0;

    // Pointers wrap naturally since Depth is a power of two
    always_ff @(posedge brq_clk) begin
        if (!brq_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AddrWidth'(push);
            rd_ptr <= rd_ptr + AddrWidth'(pop);
            count  <= count + CntWidth'(push) - CntWidth'(pop);
        end
    end

    // Storage needs no reset; stale entries are unreachable once pointers clear
    always_ff @(posedge brq_clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/brq_wb_writer.sv
// brq_wb_writer: arbitrates ALU/LSU results onto the register-file write port and tracks busy registers
module brq_wb_writer
    import brq_wb_pkg::*;
#(
    parameter int DataWidth    = DATA_W,
    parameter int AddrRegWidth = REG_AW,
    parameter int FifoDepth    = 4
) (
    input logic            brq_clk,
    input logic            brq_rst_n,
    brq_wb_writer_if.slave bus
);
    localparam int NumRegs    = 2 ** AddrRegWidth;
    localparam int EntryWidth = AddrRegWidth + DataWidth;

    wb_src_e                 src;
    logic                    fifo_full, fifo_empty, lsu_fire, push, pop, do_write;
    logic [EntryWidth-1:0]   head;
    logic [AddrRegWidth-1:0] sel_rd;
    logic [DataWidth-1:0]    sel_data;
    logic [NumRegs-1:0]      busy, set_mask, clr_mask;

    assign bus.lsu_ready    = brq_rst_n & ~fifo_full;
    assign lsu_fire         = bus.lsu_valid & bus.lsu_ready;
    assign bus.hazard_stall = busy[bus.chk_rs1] | busy[bus.chk_rs2] | busy[bus.chk_rd];

    // Fixed priority: ALU, then buffered LSU head, then LSU bypass when the buffer is empty
    always_comb begin
        src      = bus.alu_valid ? SRC_ALU : !fifo_empty ? SRC_FIFO : lsu_fire ? SRC_BYPASS : SRC_NONE;
        sel_rd   = src == SRC_ALU ? bus.alu_rd : src == SRC_FIFO ? head[DataWidth +: AddrRegWidth] : bus.lsu_rd;
        sel_data = src == SRC_ALU ? bus.alu_data : src == SRC_FIFO ? head[DataWidth-1:0] : bus.lsu_data;
        pop      = src == SRC_FIFO;
        push     = lsu_fire && src != SRC_BYPASS;
        do_write = src != SRC_NONE && sel_rd != '0;
        set_mask = (bus.issue_valid && bus.issue_long) ? NumRegs'(1) << bus.issue_rd : '0;
        clr_mask = (src == SRC_FIFO || src == SRC_BYPASS) ? NumRegs'(1) << sel_rd : '0;
    end

    brq_wb_fifo #(
        .Width (EntryWidth),
        .Depth (FifoDepth)
    ) u_fifo (
        .brq_clk   (brq_clk),
        .brq_rst_n (brq_rst_n),
        .push      (push),
        .push_data ({bus.lsu_rd, bus.lsu_data}),
        .pop       (pop),
        .pop_data  (head),
        .count     (bus.fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Write port register; index/data hold when nothing is written
    always_ff @(posedge brq_clk) begin
        if (!brq_rst_n) begin
            bus.writeEn      <= 1'b0;
            bus.writeDataSel <= '0;
            bus.writeData    <= '0;
        end else begin
            bus.writeEn <= do_write;
            if (do_write) begin
                bus.writeDataSel <= sel_rd;
                bus.writeData    <= sel_data;
            end
        end
    end

    // Busy scoreboard: set beats a same-cycle clear, x0 never busy
    always_ff @(posedge brq_clk) begin
        if (!brq_rst_n) busy <= '0;
        else busy <= ((busy & ~clr_mask) | set_mask) & ~NumRegs'(1);
    end
endmodule

// File: tb/tb_brq_wb_writer.sv
// tb_brq_wb_writer: directed and random checks of brq_wb_writer against a queue-based model
module tb_brq_wb_writer;
    import brq_wb_pkg::*;

    logic brq_clk = 1'b0;
    logic brq_rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    wb_entry_t   q[$];
    bit [31:0]   mbusy;
    bit          exp_we;
    logic [4:0]  exp_sel;
    logic [31:0] exp_data;

    always #5 brq_clk = ~brq_clk;

    brq_wb_writer_if bus ();

    brq_wb_writer u_dut (
        .brq_clk   (brq_clk),
        .brq_rst_n (brq_rst_n),
        .bus       (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.issue_valid = 0; bus.issue_long = 0; bus.issue_rd = '0;
        bus.chk_rs1 = '0; bus.chk_rs2 = '0; bus.chk_rd = '0;
        bus.alu_valid = 0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.lsu_valid = 0; bus.lsu_rd = '0; bus.lsu_data = '0;
    endtask

    // Reference: queue of waiting LSU results, priority ALU > queued > direct LSU
    task automatic model_update();
        wb_entry_t e;
        bit got, from_lsu, fire;
        fire = bus.lsu_valid && brq_rst_n && q.size() < 4;
        if (!brq_rst_n) begin
            q.delete(); mbusy = '0; exp_we = 0; exp_sel = '0; exp_data = '0;
            return;
        end
        got = 0; from_lsu = 0; e = '0;
        if (bus.alu_valid) begin
            e.rd = bus.alu_rd; e.data = bus.alu_data; got = 1;
        end else if (q.size() > 0) begin
            e = q.pop_front(); got = 1; from_lsu = 1;
        end else if (fire) begin
            e.rd = bus.lsu_rd; e.data = bus.lsu_data; got = 1; from_lsu = 1; fire = 0;
        end
        if (fire) q.push_back('{rd: bus.lsu_rd, data: bus.lsu_data});
        exp_we = got && e.rd != 0;
        if (exp_we) begin
            exp_sel = e.rd; exp_data = e.data;
        end
        if (from_lsu) mbusy[e.rd] = 0;
        if (bus.issue_valid && bus.issue_long && bus.issue_rd != 0) mbusy[bus.issue_rd] = 1;
    endtask

    task automatic step();
        #1;
        check("lsu_ready", bus.lsu_ready, brq_rst_n && q.size() < 4);
        check("fifo_count", bus.fifo_count, q.size());
        check("hazard", bus.hazard_stall, mbusy[bus.chk_rs1] | mbusy[bus.chk_rs2] | mbusy[bus.chk_rd]);
        @(posedge brq_clk);
        model_update();
        @(negedge brq_clk);
        check("writeEn", bus.writeEn, exp_we);
        check("writeDataSel", bus.writeDataSel, exp_sel);
        check("writeData", bus.writeData, exp_data);
    endtask

    initial begin
        q.delete(); mbusy = '0; exp_we = 0; exp_sel = '0; exp_data = '0;
        brq_rst_n = 0;
        idle();
        bus.lsu_valid = 1;
        repeat (2) @(posedge brq_clk);
        @(negedge brq_clk);
        for (int r = 0; r < 32; r++) begin
            bus.chk_rs1 = 5'(r); bus.chk_rs2 = 5'(r); bus.chk_rd = 5'(r);
            step();
        end
        check("rst_ready", bus.lsu_ready, 0);
        brq_rst_n = 1;
        idle();

        bus.alu_valid = 1; bus.alu_rd = 5; bus.alu_data = 32'hDEADBEEF;
        step();
        check("alu_we", bus.writeEn, 1);
        check("alu_sel", bus.writeDataSel, 5);
        check("alu_data", bus.writeData, 32'hDEADBEEF);
        idle();

        bus.issue_valid = 1; bus.issue_long = 1; bus.issue_rd = 7;
        step();
        idle();
        bus.chk_rs1 = 7;
        step();
        check("haz_rs1_7", bus.hazard_stall, 1);
        bus.lsu_valid = 1; bus.lsu_rd = 7; bus.lsu_data = 32'h1234;
        step();
        check("byp_we", bus.writeEn, 1);
        check("byp_data", bus.writeData, 32'h1234);
        check("byp_count", bus.fifo_count, 0);
        #1 check("haz_cleared", bus.hazard_stall, 0);
        idle();

        for (int i = 1; i <= 5; i++) begin
            bus.alu_valid = 1; bus.alu_rd = 5'(20 + i); bus.alu_data = $urandom;
            bus.lsu_valid = 1; bus.lsu_rd = 5'(i); bus.lsu_data = 32'(100 + i);
            step();
        end
        check("full_count", bus.fifo_count, 4);
        check("full_ready", bus.lsu_ready, 0);
        idle();
        for (int i = 1; i <= 4; i++) begin
            step();
            check("drain_sel", bus.writeDataSel, i);
            check("drain_data", bus.writeData, 100 + i);
        end
        check("drained", bus.fifo_count, 0);

        bus.lsu_valid = 1; bus.lsu_rd = 0; bus.lsu_data = 32'hBAD;
        step();
        check("x0_we", bus.writeEn, 0);
        idle();

        bus.issue_valid = 1; bus.issue_long = 1; bus.issue_rd = 9;
        step();
        idle();
        bus.lsu_valid = 1; bus.lsu_rd = 9; bus.lsu_data = 32'h99;
        bus.issue_valid = 1; bus.issue_long = 1; bus.issue_rd = 9;
        step();
        idle();
        bus.chk_rd = 9;
        #1 check("set_wins", bus.hazard_stall, 1);
        step();

        for (int i = 10; i <= 12; i++) begin
            idle();
            bus.issue_valid = 1; bus.issue_long = 1; bus.issue_rd = 5'(i);
            step();
        end
        for (int i = 10; i <= 12; i++) begin
            idle();
            bus.alu_valid = 1; bus.alu_rd = 3; bus.alu_data = $urandom;
            bus.lsu_valid = 1; bus.lsu_rd = 5'(i); bus.lsu_data = $urandom;
            step();
        end
        check("pre_rst_count", bus.fifo_count, 3);
        idle();
        brq_rst_n = 0;
        step();
        brq_rst_n = 1;
        check("post_rst_count", bus.fifo_count, 0);
        for (int i = 10; i <= 12; i++) begin
            bus.chk_rs1 = 5'(i);
            step();
            check("post_rst_we", bus.writeEn, 0);
            check("post_rst_haz", bus.hazard_stall, 0);
        end

        for (int n = 0; n < 800; n++) begin
            brq_rst_n = $urandom_range(99) != 0;
            bus.issue_valid = $urandom_range(3) == 0;
            bus.issue_long = $urandom_range(1) == 1;
            bus.issue_rd = 5'($urandom_range(15));
            bus.chk_rs1 = 5'($urandom_range(15));
            bus.chk_rs2 = 5'($urandom_range(15));
            bus.chk_rd = 5'($urandom_range(15));
            bus.alu_valid = $urandom_range(2) == 0;
            bus.alu_rd = 5'($urandom);
            bus.alu_data = $urandom;
            bus.lsu_valid = $urandom_range(1) == 1;
            bus.lsu_rd = 5'($urandom_range(15));
            bus.lsu_data = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
